// File: rtl/led_fade_pwm.sv
// -----------------------------------------------------------------------------
// led_fade_pwm
//
// Output stage between the 8-bit LED pattern generator and the board LED pins.
// Each pattern bit owns one PWM brightness channel. A lit bit jumps the
// channel to full brightness. A dropped bit lets the brightness decay linearly,
// one FADE_STEP per fade tick. This leaves a fading trail behind a rotating
// pattern.
//
// Parameters
//   PWM_BITS       brightness / PWM resolution, MAX = 2^PWM_BITS-1
//   FADE_DIV       clock cycles per fade step (1..2^24-1)
//   FADE_STEP      brightness decrement per fade step (1..MAX)
//   LED_ACTIVE_LOW 1 = invert led_out so that a lit LED drives 0
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous assert, active-low reset
//   en         1 = run, 0 = synchronous blank (levels and counters cleared)
//   pattern_in LED pattern, bit i = 1 lights LED i (same clock domain)
//   led_out    registered PWM drive to the pins
// -----------------------------------------------------------------------------
module led_fade_pwm #(
    parameter int PWM_BITS       = 8,
    parameter int FADE_DIV       = 200000,
    parameter int FADE_STEP      = 8,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] pattern_in,
    output logic [7:0] led_out
);

    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
    localparam logic [PWM_BITS-1:0] LVL_STEP = PWM_BITS'(FADE_STEP);
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
    localparam logic [23:0]         DIV_LAST = 24'(FADE_DIV - 1);
    // Pin value of a dark LED; also used as the XOR mask for active-low pins.
    localparam logic [7:0]          LED_OFF  = {8{LED_ACTIVE_LOW}};

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [23:0]         r_div_cnt;
    logic [7:0]          r_led_out;
    logic                w_fade_tick;
    logic [7:0]          w_lit;

    // With FADE_DIV = 1, DIV_LAST is 0 and the divider never leaves 0, so the
    // tick fires every cycle.
    assign w_fade_tick = (r_div_cnt == DIV_LAST);

    // Shared PWM ramp and fade divider. Both restart from 0 while blanked so
    // that the first enabled cycle is cycle 0 of each.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
            r_div_cnt <= '0;
        end else if (!en) begin
            r_pwm_cnt <= '0;
            r_div_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
            r_div_cnt <= w_fade_tick ? 24'd0 : r_div_cnt + 24'd1;
        end
    end

    // One brightness channel per LED.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_chan
            logic [PWM_BITS-1:0] r_level;

            // A live pattern bit outranks a coincident fade tick, so a re-hit
            // during a fade always restores full brightness.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_level <= '0;
                end else if (!en) begin
                    r_level <= '0;
                end else if (pattern_in[gi]) begin
                    r_level <= LVL_MAX;
                end else if (w_fade_tick) begin
                    // Saturating decrement: never wraps below zero.
                    r_level <= (r_level > LVL_STEP) ? (r_level - LVL_STEP) : '0;
                end
            end

            // Level MAX is forced on so a full-brightness LED has no dark
            // cycle when the ramp reaches MAX.
            assign w_lit[gi] = (r_level == LVL_MAX) || (r_level > r_pwm_cnt);
        end
    endgenerate

    // Registered compare stage driving the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led_out <= LED_OFF;
        end else begin
            r_led_out <= en ? (w_lit ^ LED_OFF) : LED_OFF;
        end
    end

    assign led_out = r_led_out;

endmodule

// File: tb/tb_led_fade_pwm.sv
// -----------------------------------------------------------------------------
// tb_led_fade_pwm
//
// Drives two instances (active-high and active-low pins) with PWM_BITS=4,
// FADE_DIV=32, FADE_STEP=4. Every driven cycle pushes the expected pin value
// onto a queue; the value is popped and compared after the clock edge.
// Vector records and hand-written sequences check the reset, steady-on, fade
// duty, re-hit, blank and asynchronous-reset behaviour.
// -----------------------------------------------------------------------------
module tb_led_fade_pwm;

    localparam int PB   = 4;
    localparam int FD   = 32;
    localparam int FS   = 4;
    localparam int MAXV = 15;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       en         = 1'b0;
    logic [7:0] pattern_in = 8'h00;
    logic [7:0] led_out;
    logic [7:0] led_out_al;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    int         m_pwm;
    int         m_div;
    int         m_lvl[8];
    logic [7:0] samp[0:255];

    typedef struct {
        logic       en;
        logic [7:0] pat;
        int         cycles;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[6];
    int   exp_duty[4];

    always #5 clk = ~clk;

    led_fade_pwm #(
        .PWM_BITS(PB), .FADE_DIV(FD), .FADE_STEP(FS), .LED_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pattern_in(pattern_in), .led_out(led_out)
    );

    led_fade_pwm #(
        .PWM_BITS(PB), .FADE_DIV(FD), .FADE_STEP(FS), .LED_ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .pattern_in(pattern_in), .led_out(led_out_al)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pwm = 0;
        m_div = 0;
        for (int i = 0; i < 8; i++) m_lvl[i] = 0;
    endtask

    // Drive one cycle, push the expected pin value, then pop and compare it
    // after the edge. Returns the sampled active-high output.
    task automatic run(input logic e_v, input logic [7:0] p, output logic [7:0] got);
        logic [7:0] e;
        logic [7:0] exp;
        bit         tick;
        en         = e_v;
        pattern_in = p;
        tick = (m_div == FD - 1);
        for (int i = 0; i < 8; i++)
            e[i] = e_v && ((m_lvl[i] == MAXV) || (m_lvl[i] > m_pwm));
        for (int i = 0; i < 8; i++) begin
            if (!e_v)           m_lvl[i] = 0;
            else if (p[i])      m_lvl[i] = MAXV;
            else if (tick)      m_lvl[i] = (m_lvl[i] > FS) ? m_lvl[i] - FS : 0;
        end
        if (!e_v) begin
            m_pwm = 0;
            m_div = 0;
        end else begin
            m_pwm = (m_pwm + 1) % (MAXV + 1);
            m_div = tick ? 0 : m_div + 1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = led_out;
        exp = exp_q.pop_front();
        check8("scoreboard", got, exp);
        check8("scoreboard_al", led_out_al, ~exp);
    endtask

    task automatic blank();
        logic [7:0] g;
        run(1'b0, 8'h00, g);
    endtask

    // Blank, then hold pat for 40 cycles and release it; pat is reasserted
    // for one extra cycle at index hit (use -1 for none).
    task automatic fade_run(input int n, input int hit, input logic [7:0] pat);
        logic [7:0] g;
        blank();
        for (int c = 0; c < n; c++) begin
            run(1'b1, (c < 40 || c == hit) ? pat : 8'h00, g);
            samp[c] = g;
        end
    endtask

    function automatic int count_hi(input int from, input int len);
        int n = 0;
        for (int c = from; c < from + len; c++)
            if (samp[c][0]) n++;
        return n;
    endfunction

    initial begin
        logic [7:0] g;
        int         cnt;

        tbl[0] = '{1'b1, 8'h01, 20, 8'h01};
        tbl[1] = '{1'b1, 8'hA5, 20, 8'hA5};
        tbl[2] = '{1'b1, 8'hFF, 20, 8'hFF};
        tbl[3] = '{1'b0, 8'hFF,  8, 8'h00};
        tbl[4] = '{1'b1, 8'h3C, 20, 8'h3C};
        tbl[5] = '{1'b1, 8'h80, 20, 8'h80};
        exp_duty = '{11, 7, 3, 0};

        // Reset held with everything asking for light.
        rst_n      = 1'b0;
        en         = 1'b1;
        pattern_in = 8'hFF;
        model_reset();
        repeat (4) begin
            @(posedge clk);
            #1;
            check8("reset_hold", led_out, 8'h00);
            check8("reset_hold_al", led_out_al, 8'hFF);
        end
        rst_n = 1'b1;

        // Steady patterns from a blanked start.
        for (int r = 0; r < 6; r++) begin
            blank();
            for (int k = 0; k < tbl[r].cycles; k++) begin
                run(tbl[r].en, tbl[r].pat, g);
                if (k >= 1) check8($sformatf("vector%0d_cyc%0d", r, k), g, tbl[r].exp);
            end
        end

        // Steady on, then fade out.
        fade_run(200, -1, 8'h01);
        check8("on_first_edge", samp[0], 8'h00);
        cnt = 0;
        for (int c = 1; c < 64; c++) if (!samp[c][0]) cnt++;
        check_int("steady_on_low_cycles", cnt, 0);
        cnt = 0;
        for (int c = 0; c < 200; c++) if (samp[c][7:1] != 7'd0) cnt++;
        check_int("other_leds_lit_cycles", cnt, 0);
        for (int w = 0; w < 4; w++)
            for (int p = 0; p < 2; p++)
                check_int($sformatf("fade_duty_w%0d_p%0d", w, p),
                          count_hi(64 + 32 * w + 16 * p, 16), exp_duty[w]);
        check_int("fade_tail_off", count_hi(160, 40), 0);

        // Re-hit on the fade tick that would have taken level 7 to 3.
        fade_run(192, 127, 8'h01);
        check_int("rehit_pre_level7", count_hi(96, 16), 7);
        check_int("rehit_full_on", count_hi(128, 32), 32);
        check_int("rehit_then_fade", count_hi(160, 16), 11);

        // Blank mid-fade, then re-enable.
        fade_run(100, -1, 8'h01);
        run(1'b0, 8'hA5, g);
        check8("blank_one_edge", g, 8'h00);
        run(1'b1, 8'hA5, g);
        samp[0] = g;
        check8("reenable_first_edge", g, 8'h00);
        for (int k = 1; k < 4; k++) begin
            run(1'b1, 8'hA5, g);
            samp[k] = g;
            check8("reenable_on", g, 8'hA5);
        end
        for (int k = 4; k < 48; k++) begin
            run(1'b1, 8'h00, g);
            samp[k] = g;
        end
        check_int("restart_hold_full", count_hi(4, 28), 28);
        check_int("restart_duty", count_hi(32, 16), 11);

        // Asynchronous reset between clock edges during a fade.
        fade_run(100, -1, 8'h0F);
        check8("pre_reset_lit", samp[99], 8'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        check8("async_rst", led_out, 8'h00);
        check8("async_rst_al", led_out_al, 8'hFF);
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 40; c++) begin
            run(1'b1, 8'h10, g);
            samp[c] = g;
        end
        cnt = 0;
        for (int c = 0; c < 40; c++) if ((samp[c] & 8'hEF) != 8'h00) cnt++;
        check_int("post_reset_others_off", cnt, 0);
        check8("post_reset_first", samp[0], 8'h00);
        check8("post_reset_on", samp[1], 8'h10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Output stage between the 8-bit LED pattern generator and the board LED pins. Each pattern bit drives one LED through its own PWM brightness channel. A lit bit drives the LED to full brightness at once. When the bit drops, brightness decays linearly, which gives a fading trail behind the rotating water-light pattern. Everything runs on the same clock as the pattern generator.

## Interface
- `PWM_BITS`, default 8: brightness/PWM resolution; `MAX = 2^PWM_BITS-1`.
- `FADE_DIV`, default 200000: clock cycles per fade step. Range 1..2^24-1.
- `FADE_STEP`, default 8: brightness decrement per fade step. Range 1..MAX.
- `LED_ACTIVE_LOW`, default 0: 1 inverts `led_out`, so a lit LED drives 0.
- `clk` input, 1 bit: system clock; all logic on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `en` input, 1 bit: 1 = run; 0 = synchronous blank.
- `pattern_in` input, 8 bits: LED pattern; bit i = 1 means LED i lit. Driven from a register in the `clk` domain, so no synchronizer is needed.
- `led_out` output, 8 bits, registered: PWM drive to the pins.

## Operation
- `pwm_cnt` (`PWM_BITS` wide): free-running; increments every cycle and wraps from MAX to 0.
- `div_cnt` (24 bits): counts 0..FADE_DIV-1, then wraps.
  - `fade_tick` is 1 in the cycle where `div_cnt == FADE_DIV-1`.
  - With FADE_DIV=1, `fade_tick` is 1 every cycle.
- `level[i]` (`PWM_BITS` wide, one per LED), updated per cycle in this priority order:
  1. `en == 0`: `level[i] <= 0`.
  2. `pattern_in[i] == 1`: `level[i] <= MAX`. This wins over a coincident `fade_tick`.
  3. `fade_tick`: `level[i] <= (level[i] > FADE_STEP) ? level[i] - FADE_STEP : 0`. The decrement saturates at 0 and never wraps.
  4. Otherwise: `level[i]` holds.
- Compare, registered:
  - `lit[i] = (level[i] == MAX) | (level[i] > pwm_cnt)`.
  - `led_out[i] <= en ? (lit[i] ^ LED_ACTIVE_LOW) : LED_ACTIVE_LOW`.
- Resulting duty per PWM period of 2^PWM_BITS cycles:
  - `level` = 0: 0 high cycles (fully off).
  - 0 < `level` < MAX: `level` high cycles.
  - `level` = MAX: all cycles high (fully on, no gap).
- `en` low: `pwm_cnt` and `div_cnt` reset to 0. Counting restarts from 0 on the first cycle `en` is high again.
- Fade length from MAX to 0 is `ceil(MAX/FADE_STEP)` ticks. Defaults: 32 ticks × 200000 cycles = 6.4 M cycles.

## Timing
- Reset (`rst_n` = 0, asynchronous): `pwm_cnt` = 0, `div_cnt` = 0, all `level` = 0. `led_out` is `8'h00`, or `8'hFF` when `LED_ACTIVE_LOW` = 1. This holds while `rst_n` is low regardless of `en` or `pattern_in`.
- Reset release: the first rising edge with `rst_n` = 1 is cycle 0 of both counters.
- `pattern_in[i]` goes 0→1 at edge t: `level[i]` = MAX after edge t+1; `led_out[i]` is lit after edge t+2 and stays lit every cycle while the bit is held.
- `pattern_in[i]` goes 1→0: `level[i]` holds MAX until the next `fade_tick`, then decrements once per tick.
- `led_out` always lags `level` and `pwm_cnt` by one register stage.
- `en` 1→0 at edge t: `led_out` is off after edge t+1; `level` = 0 after edge t+1.
- Reset mid-fade: all fade state is lost. No history survives reset.
- A pattern bit toggling every cycle keeps `level` at MAX on alternate cycles. Output has no glitch beyond the registered compare.

## Test plan
Parameters for all scenarios: PWM_BITS=4 (MAX=15), FADE_DIV=32, FADE_STEP=4, LED_ACTIVE_LOW=0, unless stated.
1. Reset: hold `rst_n`=0 with `pattern_in`=8'hFF, `en`=1 -> `led_out`=8'h00 throughout. Repeat with LED_ACTIVE_LOW=1 -> `led_out`=8'hFF.
2. Steady on: `pattern_in`=8'h01 after reset -> `led_out[0]`=1 from the 2nd edge onward, with no low cycle over 64 cycles; `led_out[7:1]`=0.
3. Fade: assert `pattern_in`=8'h01 for 40 cycles, then 8'h00 -> `level[0]` steps 15→11→7→3→0 at successive `fade_tick`s. Duty in each full 16-cycle PWM period inside a constant-level window is 11, 7, 3, then 0 high cycles. `led_out[0]` stays 0 after `level[0]` reaches 0.
4. Re-hit during fade: with `level[0]`=7, assert `pattern_in[0]` on the same cycle as `fade_tick` -> `level[0]`=15 next cycle (not 3), and `led_out[0]` is fully on.
5. Blank: `en`=0 during fade with `pattern_in`=8'hA5 -> `led_out`=0 after one edge and all levels 0. Re-enable `en` -> LEDs 0, 2, 5 and 7 are fully on 2 edges later; `pwm_cnt` restarts at 0.
6. Async reset mid-fade: pulse `rst_n` low between clock edges -> `led_out` clears immediately without waiting for a clock edge. After release, LEDs with their `pattern_in` bit at 0 stay off.
